// File: rtl/uio_sched_pkg.sv
// Shared types and constants for the uio pad-bus scheduler.
package uio_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT    = 3'd1,
        DRIVE  = 3'd2,
        SAMPLE = 3'd3,
        TURN   = 3'd4
    } state_t;

    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;
    localparam int         ID_W       = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter
    import uio_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);

    logic found;

    // NOTE: every output gets a default before the search so no path leaves a latch.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    gnt[i] = 1'b1;
                    idx    = ID_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uio_bus_scheduler.sv
// Round-robin time-multiplexer of the bidirectional uio pad bus; one write or
// read per grant, always followed by a released-bus turnaround.
module uio_bus_scheduler
    import uio_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int HOLD_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ID_W-1:0]   rd_id,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              busy
);

    localparam int CNT_MAX = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic            lat_write;
    logic [7:0]      lat_data;
    logic [ID_W-1:0] lat_id;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic [7:0]      win_data;
    logic            win_write;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) win_data = req_data[i*8 +: 8];
        end
    end

    assign win_write = |(req_write & gnt);
    assign busy      = (state != IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_data  <= '0;
            lat_id    <= '0;
            req_ready <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_id     <= '0;
            uio_oe    <= OE_RELEASE;
            uio_out   <= '0;
        end else if (ena) begin
            req_ready <= '0;
            rd_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= GNT;
                        req_ready <= gnt;
                        lat_write <= win_write;
                        lat_data  <= win_data;
                        lat_id    <= gnt_idx;
                        ptr       <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + ID_W'(1);
                    end
                end
                GNT: begin
                    cnt <= HOLD_LOAD;
                    if (lat_write) begin
                        state   <= DRIVE;
                        uio_oe  <= OE_DRIVE;
                        uio_out <= lat_data;
                    end else begin
                        state <= SAMPLE;
                    end
                end
                DRIVE, SAMPLE: begin
                    if (cnt == '0) begin
                        state   <= TURN;
                        cnt     <= TURN_LOAD;
                        uio_oe  <= OE_RELEASE;
                        uio_out <= '0;
                        // Read data is captured as the settle window closes.
                        if (state == SAMPLE) begin
                            rd_data  <= uio_in;
                            rd_valid <= 1'b1;
                            rd_id    <= lat_id;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                TURN: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Directed bench for uio_bus_scheduler (NREQ=2, HOLD_CYC=2, TURN_CYC=1).
module tb_uio_bus_scheduler;
    import uio_sched_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uio_bus_scheduler #(.NREQ(2), .HOLD_CYC(2), .TURN_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Contention schedule, cycles 1..14 after both requesters assert writes.
    logic [7:0] exp_ready [1:14];
    logic [7:0] exp_oe    [1:14];
    logic [7:0] exp_out   [1:14];

    initial begin
        exp_ready = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        exp_oe    = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF,
                      8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
        exp_out   = '{8'h00, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h22,
                      8'h22, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'h00};

        rst_n     = 1'b0;
        ena       = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_data  = 16'h0000;
        uio_in    = 8'h00;

        // 1. Reset, then idle
        step();
        step();
        check("rst_oe",       uio_oe,          8'h00);
        check("rst_out",      uio_out,         8'h00);
        check("rst_ready",    8'(req_ready),   8'h00);
        check("rst_rd_valid", 8'(rd_valid),    8'h00);
        check("rst_rd_data",  rd_data,         8'h00);
        check("rst_rd_id",    8'(rd_id),       8'h00);
        check("rst_busy",     8'(busy),        8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_oe", uio_oe, 8'h00);
        end

        // 2. Single write from requester 0
        req_valid = 2'b01;
        req_write = 2'b01;
        req_data  = 16'h00A5;
        step();
        check("wr_c1_ready", 8'(req_ready), 8'h01);
        check("wr_c1_busy",  8'(busy),      8'h01);
        req_valid = 2'b00;
        step();
        check("wr_c2_oe",  uio_oe,  8'hFF);
        check("wr_c2_out", uio_out, 8'hA5);
        step();
        check("wr_c3_oe",  uio_oe,  8'hFF);
        check("wr_c3_out", uio_out, 8'hA5);
        step();
        check("wr_c4_oe",  uio_oe,  8'h00);
        check("wr_c4_out", uio_out, 8'h00);
        step();
        check("wr_c5_busy", 8'(busy), 8'h00);

        // 3. Single read by requester 1
        uio_in    = 8'h3C;
        req_valid = 2'b10;
        req_write = 2'b00;
        step();
        check("rd_c1_ready", 8'(req_ready), 8'h02);
        req_valid = 2'b00;
        step();
        check("rd_c2_oe",    uio_oe,       8'h00);
        check("rd_c2_valid", 8'(rd_valid), 8'h00);
        step();
        check("rd_c3_oe",    uio_oe,       8'h00);
        step();
        check("rd_c4_valid", 8'(rd_valid), 8'h01);
        check("rd_c4_data",  rd_data,      8'h3C);
        check("rd_c4_id",    8'(rd_id),    8'h01);
        check("rd_c4_oe",    uio_oe,       8'h00);
        step();
        check("rd_c5_valid", 8'(rd_valid), 8'h00);
        check("rd_c5_busy",  8'(busy),     8'h00);

        // 4. Contention: both requesters write continuously
        req_valid = 2'b11;
        req_write = 2'b11;
        req_data  = 16'h2211;
        for (int c = 1; c <= 14; c++) begin
            step();
            check("ct_ready", 8'(req_ready), exp_ready[c]);
            check("ct_oe",    uio_oe,        exp_oe[c]);
            check("ct_out",   uio_out,       exp_out[c]);
        end
        req_valid = 2'b00;
        step();
        check("ct_end_busy", 8'(busy), 8'h00);

        // 5. Freeze for 3 cycles mid-DRIVE (pointer now at requester 1)
        req_valid = 2'b10;
        req_write = 2'b10;
        req_data  = 16'h5A00;
        step();
        check("fz_c1_ready", 8'(req_ready), 8'h02);
        req_valid = 2'b00;
        step();
        check("fz_c2_oe", uio_oe, 8'hFF);
        ena = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            check("fz_hold_oe",  uio_oe,  8'hFF);
            check("fz_hold_out", uio_out, 8'h5A);
        end
        ena = 1'b1;
        step();
        check("fz_c6_oe", uio_oe, 8'hFF);
        step();
        check("fz_c7_oe", uio_oe, 8'h00);
        step();
        check("fz_c8_busy", 8'(busy), 8'h00);

        // No grant while disabled
        ena       = 1'b0;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_data  = 16'h0077;
        step();
        step();
        check("dis_ready", 8'(req_ready), 8'h00);
        check("dis_busy",  8'(busy),      8'h00);
        ena = 1'b1;

        // 6. Reset in the second DRIVE cycle
        step();
        check("ab_c1_ready", 8'(req_ready), 8'h01);
        req_valid = 2'b00;
        step();
        check("ab_c2_out", uio_out, 8'h77);
        step();
        check("ab_c3_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        step();
        check("ab_c4_oe",    uio_oe,       8'h00);
        check("ab_c4_out",   uio_out,      8'h00);
        check("ab_c4_busy",  8'(busy),     8'h00);
        check("ab_c4_valid", 8'(rd_valid), 8'h00);
        rst_n = 1'b1;

        // Pointer reset: contended reads must go to requester 0 first
        uio_in    = 8'hC3;
        req_valid = 2'b11;
        req_write = 2'b00;
        step();
        check("ptr_ready", 8'(req_ready), 8'h01);
        req_valid = 2'b00;
        step();
        step();
        step();
        check("ptr_rd_valid", 8'(rd_valid), 8'h01);
        check("ptr_rd_id",    8'(rd_id),    8'h00);
        check("ptr_rd_data",  rd_data,      8'hC3);
        step();
        check("ptr_end_busy", 8'(busy), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
